// File: rtl/flush_station.sv
// Flush arbiter for two scanner units: grants one flush at a time, captures the
// drained byte stream into a local FIFO and forwards it over a valid/ready link.
module flush_station #(
    parameter int FIFO_DEPTH = 16,
    parameter int TIMEOUT    = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rdy_flush_a,
    input  logic        rdy_flush_b,
    input  logic [7:0]  mem_used_a,
    input  logic [7:0]  mem_used_b,
    input  logic        data_valid_a,
    input  logic [7:0]  data_a,
    input  logic        data_valid_b,
    input  logic [7:0]  data_b,
    output logic        flush_a,
    output logic        flush_b,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    output logic        active_sel,
    output logic        busy,
    output logic        xfer_done,
    output logic [15:0] xfer_count,
    output logic        overflow,
    output logic        timeout_err
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_GRANT,
        S_WAIT,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t        ps_q, ps_d;
    logic          active_sel_q, active_sel_d;
    logic          last_served_q, last_served_d;
    logic [TW-1:0] wait_q, wait_d;
    logic [15:0]   count_q, count_d;
    logic          timeout_q, timeout_d;
    logic          overflow_q;

    logic [AW:0]   wr_ptr_q, rd_ptr_q;
    logic [7:0]    fifo_mem [FIFO_DEPTH];

    logic          pick_b;
    logic          sel_valid;
    logic [7:0]    sel_data;
    logic [7:0]    sel_mem;
    logic          push;
    logic          pop;
    logic          do_push;
    logic          fifo_empty;
    logic          fifo_full;
    logic [15:0]   count_inc;

    // Larger occupancy wins; a tie goes to whichever scanner was not served last.
    always_comb begin
        pick_b = 1'b0;
        if (rdy_flush_a && rdy_flush_b) begin
            if (mem_used_b > mem_used_a)
                pick_b = 1'b1;
            else if (mem_used_a > mem_used_b)
                pick_b = 1'b0;
            else
                pick_b = !last_served_q;
        end else begin
            pick_b = rdy_flush_b;
        end
    end

    assign sel_valid = active_sel_q ? data_valid_b : data_valid_a;
    assign sel_data  = active_sel_q ? data_b : data_a;
    assign sel_mem   = active_sel_q ? mem_used_b : mem_used_a;
    assign count_inc = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;

    always_comb begin
        ps_d          = ps_q;
        active_sel_d  = active_sel_q;
        last_served_d = last_served_q;
        wait_d        = wait_q;
        count_d       = count_q;
        timeout_d     = timeout_q;
        push          = 1'b0;
        flush_a       = 1'b0;
        flush_b       = 1'b0;
        xfer_done     = 1'b0;
        case (ps_q)
            S_IDLE: begin
                if (rdy_flush_a || rdy_flush_b) begin
                    active_sel_d = pick_b;
                    ps_d         = S_GRANT;
                end
            end
            S_GRANT: begin
                flush_a = !active_sel_q;
                flush_b = active_sel_q;
                count_d = 16'd0;
                wait_d  = '0;
                ps_d    = S_WAIT;
            end
            S_WAIT: begin
                if (sel_valid) begin
                    push    = 1'b1;
                    count_d = count_inc;
                    ps_d    = S_DRAIN;
                end else if (wait_q == TW'(TIMEOUT - 1)) begin
                    timeout_d = 1'b1;
                    ps_d      = S_DONE;
                end else begin
                    wait_d = wait_q + TW'(1);
                end
            end
            S_DRAIN: begin
                if (sel_valid) begin
                    push    = 1'b1;
                    count_d = count_inc;
                end else if (sel_mem == 8'd0) begin
                    ps_d = S_DONE;
                end
            end
            S_DONE: begin
                xfer_done     = 1'b1;
                last_served_d = active_sel_q;
                ps_d          = S_IDLE;
            end
            default: ps_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ps_q          <= S_IDLE;
            active_sel_q  <= 1'b0;
            last_served_q <= 1'b1;
            wait_q        <= '0;
            count_q       <= 16'd0;
            timeout_q     <= 1'b0;
        end else begin
            ps_q          <= ps_d;
            active_sel_q  <= active_sel_d;
            last_served_q <= last_served_d;
            wait_q        <= wait_d;
            count_q       <= count_d;
            timeout_q     <= timeout_d;
        end
    end

    // Extra pointer MSB separates full from empty when the index bits match.
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop        = !fifo_empty && tx_ready;
    assign do_push    = push && (!fifo_full || pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (do_push)
                wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)
                rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push && fifo_full && !pop)
                overflow_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push)
            fifo_mem[wr_ptr_q[AW-1:0]] <= sel_data;
    end

    assign tx_valid    = !fifo_empty;
    assign tx_data     = fifo_mem[rd_ptr_q[AW-1:0]];
    assign active_sel  = active_sel_q;
    assign busy        = (ps_q != S_IDLE);
    assign xfer_count  = count_q;
    assign overflow    = overflow_q;
    assign timeout_err = timeout_q;

endmodule

// File: tb/tb_flush_station.sv
// Directed bench for flush_station: a table of arbitration vectors each run as a
// one-byte transfer, plus hand sequences for drain, overflow, timeout and reset.
module tb_flush_station;

    logic        clk = 1'b0;
    logic        reset;
    logic        rdy_flush_a, rdy_flush_b;
    logic [7:0]  mem_used_a, mem_used_b;
    logic        data_valid_a, data_valid_b;
    logic [7:0]  data_a, data_b;
    logic        flush_a, flush_b;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic        active_sel;
    logic        busy;
    logic        xfer_done;
    logic [15:0] xfer_count;
    logic        overflow;
    logic        timeout_err;

    always #5 clk = ~clk;

    flush_station #(.FIFO_DEPTH(16), .TIMEOUT(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .rdy_flush_a (rdy_flush_a),
        .rdy_flush_b (rdy_flush_b),
        .mem_used_a  (mem_used_a),
        .mem_used_b  (mem_used_b),
        .data_valid_a(data_valid_a),
        .data_a      (data_a),
        .data_valid_b(data_valid_b),
        .data_b      (data_b),
        .flush_a     (flush_a),
        .flush_b     (flush_b),
        .tx_valid    (tx_valid),
        .tx_data     (tx_data),
        .tx_ready    (tx_ready),
        .active_sel  (active_sel),
        .busy        (busy),
        .xfer_done   (xfer_done),
        .xfer_count  (xfer_count),
        .overflow    (overflow),
        .timeout_err (timeout_err)
    );

    typedef struct {
        logic       ra;
        logic       rb;
        logic [7:0] ma;
        logic [7:0] mb;
        logic [7:0] db;
        logic       exp_sel;
    } vec_t;

    int         tests = 0;
    int         fails = 0;
    logic [7:0] rxq[$];
    int         done_cnt = 0;

    // Record every accepted tx byte and every done pulse.
    always @(posedge clk) begin
        if (!reset) begin
            if (tx_valid && tx_ready)
                rxq.push_back(tx_data);
            if (xfer_done)
                done_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        rdy_flush_a = v.ra;
        rdy_flush_b = v.rb;
        mem_used_a  = v.ma;
        mem_used_b  = v.mb;
        tx_ready    = 1'b1;
        rxq.delete();
        tick();
        chk($sformatf("v%0d flush_a", idx), flush_a, !v.exp_sel);
        chk($sformatf("v%0d flush_b", idx), flush_b, v.exp_sel);
        chk($sformatf("v%0d active_sel", idx), active_sel, v.exp_sel);
        chk($sformatf("v%0d busy", idx), busy, 1);
        rdy_flush_a = 1'b0;
        rdy_flush_b = 1'b0;
        mem_used_a  = 8'd0;
        mem_used_b  = 8'd0;
        tick();
        chk($sformatf("v%0d flush pulse", idx), flush_a | flush_b, 0);
        if (v.exp_sel) begin
            data_valid_b = 1'b1;
            data_b       = v.db;
        end else begin
            data_valid_a = 1'b1;
            data_a       = v.db;
        end
        tick();
        data_valid_a = 1'b0;
        data_valid_b = 1'b0;
        tick();
        chk($sformatf("v%0d xfer_done", idx), xfer_done, 1);
        chk($sformatf("v%0d xfer_count", idx), xfer_count, 1);
        tick();
        chk($sformatf("v%0d idle", idx), busy, 0);
        chk($sformatf("v%0d rx size", idx), rxq.size(), 1);
        if (rxq.size() == 1)
            chk($sformatf("v%0d rx byte", idx), rxq[0], v.db);
        $display("[TB] vec %0d rdy=%0d%0d mem=%0d/%0d sel=%0d", idx, v.ra, v.rb, v.ma, v.mb, active_sel);
    endtask

    task automatic start_xfer(input logic sel, input logic [7:0] m);
        if (sel) begin
            rdy_flush_b = 1'b1;
            mem_used_b  = m;
        end else begin
            rdy_flush_a = 1'b1;
            mem_used_a  = m;
        end
        tick();
        rdy_flush_a = 1'b0;
        rdy_flush_b = 1'b0;
        tick();
    endtask

    vec_t vecs[6];

    initial begin
        vecs[0] = '{ra:1'b1, rb:1'b0, ma:8'd85,  mb:8'd0,  db:8'hA1, exp_sel:1'b0};
        vecs[1] = '{ra:1'b1, rb:1'b1, ma:8'd90,  mb:8'd95, db:8'hB2, exp_sel:1'b1};
        vecs[2] = '{ra:1'b1, rb:1'b1, ma:8'd92,  mb:8'd92, db:8'hC3, exp_sel:1'b0};
        vecs[3] = '{ra:1'b1, rb:1'b1, ma:8'd92,  mb:8'd92, db:8'hD4, exp_sel:1'b1};
        vecs[4] = '{ra:1'b0, rb:1'b1, ma:8'd99,  mb:8'd82, db:8'hE5, exp_sel:1'b1};
        vecs[5] = '{ra:1'b1, rb:1'b1, ma:8'd100, mb:8'd50, db:8'hF6, exp_sel:1'b0};

        reset = 1'b1;
        rdy_flush_a = 1'b0; rdy_flush_b = 1'b0;
        mem_used_a = 8'd0;  mem_used_b = 8'd0;
        data_valid_a = 1'b0; data_valid_b = 1'b0;
        data_a = 8'd0; data_b = 8'd0;
        tx_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        chk("rst busy", busy, 0);
        chk("rst flush", {flush_a, flush_b}, 0);
        chk("rst tx_valid", tx_valid, 0);
        chk("rst flags", {xfer_done, overflow, timeout_err, active_sel}, 0);
        chk("rst xfer_count", xfer_count, 0);

        for (int i = 0; i < 6; i++)
            run_vec(vecs[i], i);

        // Ten-byte drain from A with the link always ready.
        rxq.delete();
        done_cnt = 0;
        tx_ready = 1'b1;
        start_xfer(1'b0, 8'd85);
        for (int i = 1; i <= 10; i++) begin
            data_valid_a = 1'b1;
            data_a       = 8'(i);
            mem_used_a   = 8'd50;
            tick();
        end
        data_valid_a = 1'b0;
        mem_used_a   = 8'd0;
        tick();
        chk("drain xfer_done", xfer_done, 1);
        chk("drain xfer_count", xfer_count, 10);
        tick();
        tick();
        chk("drain done_cnt", done_cnt, 1);
        chk("drain rx size", rxq.size(), 10);
        for (int i = 0; i < 10 && i < rxq.size(); i++)
            chk($sformatf("drain byte %0d", i), rxq[i], i + 1);
        $display("[TB] drain 10 bytes count=%0d rx=%0d", xfer_count, rxq.size());

        // Twenty bytes into a 16-entry FIFO with the link stalled.
        rxq.delete();
        tx_ready = 1'b0;
        start_xfer(1'b0, 8'd90);
        for (int i = 0; i < 20; i++) begin
            data_valid_a = 1'b1;
            data_a       = 8'h40 + 8'(i);
            mem_used_a   = 8'd60;
            tick();
            if (i == 15)
                chk("ovf before full push", overflow, 0);
        end
        chk("ovf set", overflow, 1);
        data_valid_a = 1'b0;
        mem_used_a   = 8'd0;
        tick();
        chk("ovf xfer_count", xfer_count, 20);
        tick();
        tx_ready = 1'b1;
        for (int i = 0; i < 18; i++)
            tick();
        chk("ovf rx size", rxq.size(), 16);
        for (int i = 0; i < 16 && i < rxq.size(); i++)
            chk($sformatf("ovf byte %0d", i), rxq[i], 8'h40 + i);
        chk("ovf empty", tx_valid, 0);
        chk("ovf sticky", overflow, 1);
        $display("[TB] overflow 20 bytes stored=%0d ovf=%0d", rxq.size(), overflow);

        // Flush with no data: timeout after 32 waiting cycles.
        start_xfer(1'b0, 8'd85);
        for (int i = 0; i < 31; i++)
            tick();
        chk("to still waiting", {busy, xfer_done, timeout_err}, 3'b100);
        tick();
        chk("to xfer_done", xfer_done, 1);
        chk("to timeout_err", timeout_err, 1);
        chk("to xfer_count", xfer_count, 0);
        tick();
        chk("to idle", busy, 0);
        chk("to sticky", timeout_err, 1);
        mem_used_a = 8'd0;
        $display("[TB] timeout err=%0d", timeout_err);

        // Reset while draining B.
        tx_ready = 1'b0;
        start_xfer(1'b1, 8'd85);
        for (int i = 0; i < 3; i++) begin
            data_valid_b = 1'b1;
            data_b       = 8'h70 + 8'(i);
            mem_used_b   = 8'd40;
            tick();
        end
        reset = 1'b1;
        tick();
        chk("mrst busy", busy, 0);
        chk("mrst tx_valid", tx_valid, 0);
        chk("mrst flags", {overflow, timeout_err, xfer_done, active_sel}, 0);
        chk("mrst xfer_count", xfer_count, 0);
        reset        = 1'b0;
        data_valid_b = 1'b0;
        mem_used_b   = 8'd0;
        run_vec('{ra:1'b1, rb:1'b1, ma:8'd50, mb:8'd50, db:8'h5A, exp_sel:1'b0}, 6);
        $display("[TB] reset mid-drain recovered");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
